bcd_cascade_counter: RTL

- Multi-digit cascaded decade (BCD) counter with a built-in prescaler.
- Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit digit output drives one decoder instance.
- Provides synchronous clear, parallel load, up/down counting, and a wrap pulse so chains of counters can themselves be cascaded.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit.sv | 48 ++++
 rtl/bcd_cascade_counter.sv | 80 ++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter slice.
//   BCD_W    : width of one decade digit
//   BCD_MAX  : largest legal digit value (9)
//   BCD_MIN  : smallest legal digit value (0)
//   bcd_sat  : clamps a raw 4-bit field into the legal 0..9 range
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  // Any non-decimal nibble (10..15) is pinned to 9 so a digit can never
  // leave the decimal range, whatever is presented on the load bus.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] in);
    return (in > BCD_MAX) ? BCD_MAX : in;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0..9) cell of the cascaded BCD counter.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   clr      : synchronous clear (beats load and counting)
//   load     : synchronous parallel load of ld_val (saturated to 9)
//   ld_val   : raw load nibble for this digit
//   step     : count step qualifier from the prescaler
//   up_dn    : 1 = count up, 0 = count down
//   cin      : all lower digits are at their rollover value
//   q        : registered digit value, always 0..9
//   cout     : this digit and all below it are at their rollover value
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             step,
  input  logic             up_dn,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // Purely combinational so the whole chain settles within one cycle and
  // every digit updates on the same edge.
  assign cout = cin & (up_dn ? (q == BCD_MAX) : (q == BCD_MIN));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= bcd_sat(ld_val);
    end else if (step && cin) begin
      if (up_dn) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit cascaded BCD counter with prescaler.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset (highest priority)
//   en       : count enable; freezes prescaler and digits when low
//   up_dn    : 1 = count up, 0 = count down (sampled on step edges)
//   clr      : synchronous clear of digits and prescaler
//   load     : synchronous parallel load of load_val
//   load_val : BCD load value, digit i at [4i+3:4i], fields > 9 clamp to 9
//   digits   : registered BCD value, digit 0 least significant
//   tick     : one-cycle pulse coincident with each new stepped value
//   wrap     : one-cycle pulse with tick when the value wrapped around
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000000,
  parameter int PRE_W      = 26
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          clr,
  input  logic                          load,
  input  logic [BCD_W*NUM_DIGITS-1:0]   load_val,
  output logic [BCD_W*NUM_DIGITS-1:0]   digits,
  output logic                          tick,
  output logic                          wrap
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic                step;
  logic [NUM_DIGITS:0] carry;

  // A step is the edge on which the prescaler rolls over. clr/load take
  // precedence inside each digit, so no extra gating is needed here.
  assign step     = en && (pre_cnt == PRE_LAST);
  assign carry[0] = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n || clr || load) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (step) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
      // Carry out of the top digit means every digit was at its rollover
      // value in the counting direction: a full wrap.
      wrap    <= carry[NUM_DIGITS];
    end else begin
      if (en) begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .load    (load),
        .ld_val  (load_val[gi*BCD_W +: BCD_W]),
        .step    (step),
        .up_dn   (up_dn),
        .cin     (carry[gi]),
        .q       (digits[gi*BCD_W +: BCD_W]),
        .cout    (carry[gi+1])
      );
    end
  endgenerate

endmodule
